// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
// Used by uart_rx_fifo and the uart_tx successor.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is presented while not empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_rd    = i_pop && !w_empty;
  // When full, the write slot is the head being popped, so both may proceed.
  assign w_wr    = i_push && (!w_full || w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-glitch rejection, sticky error flags and a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to expect and check a parity bit between data and stop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_rx,
  output logic [DATA_BITS-1:0]        o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_frame_err,
  output logic                        o_overrun,
  output logic                        o_parity_err,
  input  logic                        i_clear_err
);

  localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 r_rx_meta;
  logic                 r_rx_s;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_frame_set;
  logic                 w_ovr_set;
  logic                 w_full;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick      = (r_cnt == '0);
  assign w_push      = (r_state == STOP) && w_tick && r_rx_s;
  assign w_frame_set = (r_state == STOP) && w_tick && !r_rx_s;
  assign w_ovr_set   = w_push && w_full && !i_ready;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_par_exp;

  assign w_par_exp = (^r_shift) ^ PARITY_ODD[0];
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      // Timed states count down to the next bit centre unless they reload below.
      if (r_state != IDLE && r_state != BREAK && !w_tick) r_cnt <= r_cnt - 1'b1;
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (w_tick) begin
            if (!r_rx_s) begin
              r_state <= DATA;
              r_cnt   <= FULL_LOAD;
              r_idx   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_cnt   <= FULL_LOAD;
            if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_par_bad <= (r_rx_s != w_par_exp);
            r_state   <= STOP;
            r_cnt     <= FULL_LOAD;
          end
        end
`endif
        STOP: begin
          if (w_tick) r_state <= r_rx_s ? IDLE : BREAK;
        end
        BREAK: begin
          if (r_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A new error event on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_set)      r_frame_err <= 1'b1;
      else if (i_clear_err) r_frame_err <= 1'b0;
      if (w_ovr_set)        r_overrun   <= 1'b1;
      else if (i_clear_err) r_overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_parity_err <= 1'b0;
    end else if (w_push && r_par_bad) begin
      r_parity_err <= 1'b1;
    end else if (i_clear_err) begin
      r_parity_err <= 1'b0;
    end
  end

  assign o_parity_err = r_parity_err;
`else
  logic w_unused_parity_odd;

  assign w_unused_parity_odd = PARITY_ODD[0];
  assign o_parity_err        = 1'b0;
`endif

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_push (w_push),
    .i_data (r_shift),
    .i_pop  (i_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_full (w_full),
    .o_count(o_count)
  );

  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences and random traffic
// checked against a queue-based model of the receive stream.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_ready;
  logic       i_clear_err;
  logic [7:0] o_data;
  logic       o_valid;
  logic [4:0] o_count;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovr;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_count;
    bit         exp_fe;
  } vec_t;

  always #5 i_clk = ~i_clk;

  uart_rx_fifo #(
    .CLK_HZ    (1_600_000),
    .BAUD      (100_000),
    .DATA_BITS (8),
    .FIFO_DEPTH(16),
    .PARITY_ODD(0)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_count     (o_count),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_parity_err(o_parity_err),
    .i_clear_err (i_clear_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (CPB) tick();
  endtask

  // Start bit, data LSB first and (when built) the parity bit; the stop bit is left to callers.
  task automatic send_head(input logic [7:0] d, input bit par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip);
    send_head(d, par_flip);
    drive_bit(stop);
  endtask

  task automatic model_push(input logic [7:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic clear_flags();
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Drain with a random ready pattern, comparing every accepted byte with the model.
  task automatic drain(input string name);
    int cyc = 0;
    while (q.size() != 0 && cyc < 400) begin
      i_ready = 1'($urandom_range(1));
      check({name, "_valid"}, o_valid, 1);
      if (i_ready && o_valid) begin
        check({name, "_data"}, o_data, q[0]);
        void'(q.pop_front());
      end
      tick();
      cyc++;
    end
    i_ready = 1'b0;
    check({name, "_drain_left"}, q.size(), 0);
    check({name, "_empty_valid"}, o_valid, 0);
    check({name, "_empty_count"}, o_count, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{data: 8'h5A, stop: 1'b1, exp_count: 1, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_count: 2, exp_fe: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_count: 3, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h81, stop: 1'b0, exp_count: 3, exp_fe: 1'b1};
    vecs[4] = '{data: 8'h3C, stop: 1'b1, exp_count: 4, exp_fe: 1'b1};

    i_reset = 1'b1;
    i_rx = 1'b1;
    i_ready = 1'b0;
    i_clear_err = 1'b0;
    m_ovr = 1'b0;
    repeat (3) tick();
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_data", o_data, 0);
    check("rst_fe", o_frame_err, 0);
    check("rst_ovr", o_overrun, 0);
    check("rst_pe", o_parity_err, 0);
    i_reset = 1'b0;
    repeat (4) tick();

    // First byte latency: valid appears exactly one clock after the stop-centre edge.
    i_ready = 1'b1;
    send_head(8'hA5, 1'b0);
    i_rx = 1'b1;
    repeat (10) tick();
    check("lat_before", o_valid, 0);
    tick();
    check("lat_valid", o_valid, 1);
    check("lat_data", o_data, 8'hA5);
    repeat (5) tick();
    check("lat_popped", o_valid, 0);
    check("lat_fe", o_frame_err, 0);
    check("lat_ovr", o_overrun, 0);
    check("lat_pe", o_parity_err, 0);
    i_ready = 1'b0;
    drive_bit(1'b1);

    // Short low glitch must not start a frame.
    i_rx = 1'b0;
    repeat (4) tick();
    i_rx = 1'b1;
    repeat (40) tick();
    check("glitch_count", o_count, 0);
    check("glitch_valid", o_valid, 0);
    check("glitch_fe", o_frame_err, 0);
    check("glitch_ovr", o_overrun, 0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      if (vecs[i].stop) model_push(vecs[i].data);
      check($sformatf("vec%0d_count", i), o_count, vecs[i].exp_count);
      check($sformatf("vec%0d_fe", i), o_frame_err, vecs[i].exp_fe);
      if (!vecs[i].stop) drive_bit(1'b1);
    end
    drain("vec");
    clear_flags();
    check("vec_fe_cleared", o_frame_err, 0);

    // Overrun: 17 bytes into 16 entries with no consumer.
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_push(8'(i));
    end
    check("ovr_count", o_count, 16);
    check("ovr_flag", o_overrun, 1);
    check("ovr_model", m_ovr, o_overrun);
    drain("ovr");
    clear_flags();
    check("ovr_cleared", o_overrun, 0);

    // Held-low line after a bad stop bit yields a single frame error.
    send_head(8'h3C, 1'b0);
    drive_bit(1'b0);
    check("brk_fe", o_frame_err, 1);
    check("brk_count", o_count, 0);
    repeat (20 * CPB) tick();
    clear_flags();
    check("brk_clear", o_frame_err, 0);
    repeat (20 * CPB) tick();
    check("brk_once", o_frame_err, 0);
    drive_bit(1'b1);
    check("brk_idle", o_frame_err, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    model_push(8'h3C);
    check("brk_next_count", o_count, 1);
    check("brk_next_data", o_data, 8'h3C);
    drain("brk");

    // Clear coincident with a new frame error: the error wins.
    send_head(8'h11, 1'b0);
    i_rx = 1'b0;
    repeat (10) tick();
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
    check("clr_vs_err", o_frame_err, 1);
    repeat (5) tick();
    drive_bit(1'b1);
    clear_flags();
    check("clr_after", o_frame_err, 0);

    // Full FIFO with a pop on the exact push edge.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d = 8'($urandom);
      send_frame(d, 1'b1, 1'b0);
      model_push(d);
    end
    check("pp_full", o_count, 16);
    send_head(8'h99, 1'b0);
    i_rx = 1'b1;
    repeat (10) tick();
    i_ready = 1'b1;
    check("pp_head", o_data, q[0]);
    tick();
    i_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h99);
    check("pp_count", o_count, 16);
    check("pp_ovr", o_overrun, 0);
    repeat (5) tick();
    drain("pp");

    // Random bursts of back-to-back frames.
    for (int r = 0; r < 5; r++) begin
      int n = int'($urandom_range(20, 1));
      for (int k = 0; k < n; k++) begin
        logic [7:0] d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0);
        model_push(d);
      end
      check($sformatf("rnd%0d_count", r), o_count, q.size());
      check($sformatf("rnd%0d_ovr", r), o_overrun, m_ovr);
      drain($sformatf("rnd%0d", r));
      clear_flags();
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    model_push(8'h07);
    check("par_ok", o_parity_err, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    model_push(8'h07);
    check("par_bad", o_parity_err, 1);
    check("par_count", o_count, 2);
    drain("par");
    clear_flags();
    check("par_cleared", o_parity_err, 0);
`endif

    // Reset in the middle of a frame with data and a flag pending.
    send_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h24, 1'b0, 1'b0);
    drive_bit(1'b1);
    check("mid_pre_count", o_count, 1);
    check("mid_pre_fe", o_frame_err, 1);
    i_rx = 1'b0;
    repeat (40) tick();
    i_reset = 1'b1;
    i_rx = 1'b1;
    tick();
    check("mid_valid", o_valid, 0);
    check("mid_count", o_count, 0);
    check("mid_data", o_data, 0);
    check("mid_fe", o_frame_err, 0);
    check("mid_ovr", o_overrun, 0);
    check("mid_pe", o_parity_err, 0);
    i_reset = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    repeat (20) tick();
    send_frame(8'h6E, 1'b1, 1'b0);
    model_push(8'h6E);
    drain("mid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
